// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID state and hazard controls in, EX-side operands and control out.
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5
);
  logic            stall, flush;
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic [RW-1:0]   id_rs1, id_rs2, id_rd;
  logic            id_alusrc;
  logic [3:0]      id_alucontrol;
  logic            id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch;
  logic            mem_regwrite, wb_regwrite;
  logic [RW-1:0]   mem_rd, wb_rd;
  logic [XLEN-1:0] mem_result, wb_result;

  logic            load_use_stall, ex_valid;
  logic [XLEN-1:0] alu_a, alu_b, ex_store_data, ex_pc, ex_imm;
  logic [3:0]      alu_control;
  logic [RW-1:0]   ex_rd;
  logic            ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;

  modport master (
    output stall, flush, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1, id_rs2, id_rd, id_alusrc, id_alucontrol, id_regwrite, id_memread,
           id_memwrite, id_memtoreg, id_branch, mem_regwrite, mem_rd, mem_result,
           wb_regwrite, wb_rd, wb_result,
    input  load_use_stall, ex_valid, alu_a, alu_b, alu_control, ex_store_data,
           ex_pc, ex_imm, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1, id_rs2, id_rd, id_alusrc, id_alucontrol, id_regwrite, id_memread,
           id_memwrite, id_memtoreg, id_branch, mem_regwrite, mem_rd, mem_result,
           wb_regwrite, wb_rd, wb_result,
    output load_use_stall, ex_valid, alu_a, alu_b, alu_control, ex_store_data,
           ex_pc, ex_imm, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB capture bypass, stall refresh and EX/MEM, MEM/WB operand forwarding.
module id_ex_opnd #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   ex_rs,
  input  logic [XLEN-1:0] id_rsd,
  input  logic [XLEN-1:0] ex_rsd,
  input  logic            mem_regwrite,
  input  logic [RW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_regwrite,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] cap_rsd,
  output logic [XLEN-1:0] held_rsd,
  output logic [XLEN-1:0] fwd
);
  logic wb_id_hit, wb_ex_hit, mem_ex_hit;

  assign wb_id_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == id_rs);
  assign wb_ex_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_rs);
  assign mem_ex_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs);

  assign cap_rsd  = wb_id_hit ? wb_result : id_rsd;
  // held_rsd doubles as the WB-forwarded operand; MEM overrides it.
  assign held_rsd = wb_ex_hit ? wb_result : ex_rsd;
  assign fwd      = mem_ex_hit ? mem_result : held_rsd;
endmodule

module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic                  valid, regwrite, memread, memwrite, memtoreg, branch, alusrc;
    logic [3:0]            aluc;
    logic [XLEN-1:0]       pc, imm;
    logic [RW-1:0]         rd;
    logic [1:0][RW-1:0]    rs;
    logic [1:0][XLEN-1:0]  rsd;
  } ex_t;

  ex_t                  ex_q, cap;
  logic [1:0][RW-1:0]   id_rs;
  logic [1:0][XLEN-1:0] id_rsd, cap_rsd, held_rsd, fwd;
  logic                 lus;

  assign id_rs  = {bus.id_rs2, bus.id_rs1};
  assign id_rsd = {bus.id_rs2_data, bus.id_rs1_data};

  for (genvar g = 0; g < 2; g++) begin : g_opnd
    id_ex_opnd #(.XLEN(XLEN), .RW(RW)) u_opnd (
      .id_rs       (id_rs[g]),
      .ex_rs       (ex_q.rs[g]),
      .id_rsd      (id_rsd[g]),
      .ex_rsd      (ex_q.rsd[g]),
      .mem_regwrite(bus.mem_regwrite),
      .mem_rd      (bus.mem_rd),
      .mem_result  (bus.mem_result),
      .wb_regwrite (bus.wb_regwrite),
      .wb_rd       (bus.wb_rd),
      .wb_result   (bus.wb_result),
      .cap_rsd     (cap_rsd[g]),
      .held_rsd    (held_rsd[g]),
      .fwd         (fwd[g])
    );
  end

  assign lus = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && bus.id_valid &&
               ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));

  always_comb begin
    cap          = '0;
    cap.valid    = bus.id_valid;
    cap.regwrite = bus.id_regwrite;
    cap.memread  = bus.id_memread;
    cap.memwrite = bus.id_memwrite;
    cap.memtoreg = bus.id_memtoreg;
    cap.branch   = bus.id_branch;
    cap.alusrc   = bus.id_alusrc;
    cap.aluc     = bus.id_alucontrol;
    cap.pc       = bus.id_pc;
    cap.imm      = bus.id_imm;
    cap.rd       = bus.id_rd;
    cap.rs       = id_rs;
    cap.rsd      = cap_rsd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ex_q     <= '0;
    else if (bus.flush)  ex_q     <= '0;
    else if (bus.stall)  ex_q.rsd <= held_rsd;
    else if (lus)        ex_q     <= '0;
    else                 ex_q     <= cap;
  end

  assign bus.load_use_stall = lus;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.alu_a          = fwd[0];
  assign bus.alu_b          = ex_q.alusrc ? ex_q.imm : fwd[1];
  assign bus.ex_store_data  = fwd[1];
  assign bus.alu_control    = ex_q.aluc;
  assign bus.ex_pc          = ex_q.pc;
  assign bus.ex_imm         = ex_q.imm;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_regwrite    = ex_q.regwrite;
  assign bus.ex_memread     = ex_q.memread;
  assign bus.ex_memwrite    = ex_q.memwrite;
  assign bus.ex_memtoreg    = ex_q.memtoreg;
  assign bus.ex_branch      = ex_q.branch;
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized + directed bench for id_ex_stage against a cycle-level reference model.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .RW(RW)) bus();
  id_ex_stage #(.XLEN(XLEN), .RW(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        v, rw, mr, mw, mt, br, as;
    logic [3:0]  op;
    logic [31:0] pc, imm, d1, d2;
    logic [4:0]  rs1, rs2, rd;
  } mdl_t;

  mdl_t m;
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mdl_t bubble();
    mdl_t b;
    b = '{v:0, rw:0, mr:0, mw:0, mt:0, br:0, as:0, op:0, pc:0, imm:0, d1:0, d2:0, rs1:0, rs2:0, rd:0};
    return b;
  endfunction

  // Operand as the ALU should see it: newest producer wins, x0 never forwarded.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] stored);
    if (bus.mem_regwrite && r != 0 && bus.mem_rd == r) return bus.mem_result;
    if (bus.wb_regwrite && r != 0 && bus.wb_rd == r)   return bus.wb_result;
    return stored;
  endfunction

  function automatic logic wb_gives(input logic [4:0] r);
    return bus.wb_regwrite && r != 0 && bus.wb_rd == r;
  endfunction

  function automatic logic exp_lus();
    return m.v && m.mr && m.rd != 0 && bus.id_valid && (m.rd == bus.id_rs1 || m.rd == bus.id_rs2);
  endfunction

  task automatic check_all(input string t);
    chk({t, ".valid"}, 32'(bus.ex_valid), 32'(m.v));
    chk({t, ".alu_a"}, bus.alu_a, operand(m.rs1, m.d1));
    chk({t, ".alu_b"}, bus.alu_b, m.as ? m.imm : operand(m.rs2, m.d2));
    chk({t, ".store"}, bus.ex_store_data, operand(m.rs2, m.d2));
    chk({t, ".aluc"}, 32'(bus.alu_control), 32'(m.op));
    chk({t, ".pc"}, bus.ex_pc, m.pc);
    chk({t, ".imm"}, bus.ex_imm, m.imm);
    chk({t, ".rd"}, 32'(bus.ex_rd), 32'(m.rd));
    chk({t, ".ctrl"}, 32'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg, bus.ex_branch}),
        32'({m.rw, m.mr, m.mw, m.mt, m.br}));
    chk({t, ".lus"}, 32'(bus.load_use_stall), 32'(exp_lus()));
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    mdl_t nx;
    nx = m;
    if (bus.flush) nx = bubble();
    else if (bus.stall) begin
      if (wb_gives(m.rs1)) nx.d1 = bus.wb_result;
      if (wb_gives(m.rs2)) nx.d2 = bus.wb_result;
    end else if (exp_lus()) nx = bubble();
    else begin
      nx.v = bus.id_valid; nx.rw = bus.id_regwrite; nx.mr = bus.id_memread;
      nx.mw = bus.id_memwrite; nx.mt = bus.id_memtoreg; nx.br = bus.id_branch;
      nx.as = bus.id_alusrc; nx.op = bus.id_alucontrol; nx.pc = bus.id_pc; nx.imm = bus.id_imm;
      nx.rs1 = bus.id_rs1; nx.rs2 = bus.id_rs2; nx.rd = bus.id_rd;
      nx.d1 = wb_gives(bus.id_rs1) ? bus.wb_result : bus.id_rs1_data;
      nx.d2 = wb_gives(bus.id_rs2) ? bus.wb_result : bus.id_rs2_data;
    end
    @(posedge clk);
    m = rst_n ? nx : bubble();
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_pc = 0; bus.id_imm = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0; bus.id_alusrc = 0; bus.id_alucontrol = 0;
    bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0; bus.id_memtoreg = 0; bus.id_branch = 0;
    bus.mem_regwrite = 0; bus.mem_rd = 0; bus.mem_result = 0;
    bus.wb_regwrite = 0; bus.wb_rd = 0; bus.wb_result = 0;
  endtask

  task automatic randomize_inputs();
    bus.stall = ($urandom_range(0, 5) == 0);
    bus.flush = ($urandom_range(0, 11) == 0);
    bus.id_valid = ($urandom_range(0, 7) != 0);
    bus.id_pc = $urandom; bus.id_imm = $urandom;
    bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
    bus.id_rs1 = 5'($urandom_range(0, 4)); bus.id_rs2 = 5'($urandom_range(0, 4));
    bus.id_rd = 5'($urandom_range(0, 4));
    bus.id_alusrc = 1'($urandom_range(0, 1)); bus.id_alucontrol = 4'($urandom_range(0, 7));
    bus.id_regwrite = 1'($urandom_range(0, 1)); bus.id_memread = ($urandom_range(0, 2) == 0);
    bus.id_memwrite = 1'($urandom_range(0, 1)); bus.id_memtoreg = 1'($urandom_range(0, 1));
    bus.id_branch = 1'($urandom_range(0, 1));
    bus.mem_regwrite = 1'($urandom_range(0, 1)); bus.mem_rd = 5'($urandom_range(0, 4));
    bus.mem_result = $urandom;
    bus.wb_regwrite = 1'($urandom_range(0, 1)); bus.wb_rd = 5'($urandom_range(0, 4));
    bus.wb_result = $urandom;
  endtask

  initial begin
    idle();
    m = bubble();
    #3;
    chk("reset.valid", 32'(bus.ex_valid), 32'd0);
    chk("reset.alu_a", bus.alu_a, 32'd0);
    check_all("reset");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // basic capture
    bus.id_valid = 1; bus.id_rs1 = 1; bus.id_rs2 = 2; bus.id_rd = 9;
    bus.id_rs1_data = 5; bus.id_rs2_data = 7; bus.id_alucontrol = 4'b0010;
    tick();
    chk("basic.alu_a", bus.alu_a, 32'd5);
    chk("basic.alu_b", bus.alu_b, 32'd7);
    chk("basic.aluc", 32'(bus.alu_control), 32'd2);
    chk("basic.valid", 32'(bus.ex_valid), 32'd1);
    check_all("basic");

    // forwarding priority
    bus.id_rs1 = 3; bus.id_rs1_data = 32'h11;
    tick();
    bus.mem_regwrite = 1; bus.mem_rd = 3; bus.mem_result = 32'hAAAA;
    bus.wb_regwrite = 1; bus.wb_rd = 3; bus.wb_result = 32'hBBBB;
    #1 chk("fwd.mem", bus.alu_a, 32'hAAAA);
    bus.mem_regwrite = 0;
    #1 chk("fwd.wb", bus.alu_a, 32'hBBBB);
    bus.mem_regwrite = 1; bus.mem_rd = 0; bus.wb_rd = 0;
    #1 chk("fwd.x0", bus.alu_a, 32'h11);
    check_all("fwd");
    idle();

    // load-use: load to x4 in EX, consumer reads x4 as rs2
    bus.id_valid = 1; bus.id_memread = 1; bus.id_regwrite = 1; bus.id_rd = 4; bus.id_rs1 = 1; bus.id_rs2 = 2;
    tick();
    bus.id_memread = 0; bus.id_rd = 7; bus.id_rs1 = 0; bus.id_rs2 = 4; bus.id_rs2_data = 32'hDEAD;
    #1 chk("lu.stall", 32'(bus.load_use_stall), 32'd1);
    check_all("lu.pre");
    tick();
    chk("lu.bubble", 32'(bus.ex_valid), 32'd0);
    chk("lu.clear", 32'(bus.load_use_stall), 32'd0);
    bus.wb_regwrite = 1; bus.wb_rd = 4; bus.wb_result = 32'hCAFE;
    tick();
    bus.wb_regwrite = 0;
    #1 chk("lu.cap", 32'(bus.ex_rd), 32'd7);
    chk("lu.bypass", bus.ex_store_data, 32'hCAFE);
    check_all("lu.post");

    // stall refresh on stored rs2
    idle();
    bus.id_valid = 1; bus.id_rs2 = 6; bus.id_rs2_data = 32'h55; bus.id_rd = 2;
    tick();
    bus.stall = 1; bus.wb_regwrite = 1; bus.wb_rd = 6; bus.wb_result = 32'h1234;
    repeat (3) tick();
    bus.stall = 0; bus.wb_regwrite = 0;
    #1 chk("refresh.store", bus.ex_store_data, 32'h1234);
    check_all("refresh");

    // flush beats stall
    bus.id_regwrite = 1; bus.id_alucontrol = 4'b0110;
    tick();
    bus.flush = 1; bus.stall = 1;
    tick();
    chk("flush.valid", 32'(bus.ex_valid), 32'd0);
    chk("flush.rw", 32'(bus.ex_regwrite), 32'd0);
    chk("flush.aluc", 32'(bus.alu_control), 32'd0);
    bus.flush = 0; bus.stall = 0;

    // async reset between edges
    tick();
    #2 rst_n = 0;
    #1 m = bubble();
    chk("areset.valid", 32'(bus.ex_valid), 32'd0);
    chk("areset.pc", bus.ex_pc, 32'd0);
    check_all("areset");
    @(posedge clk); #1;
    check_all("areset.hold");
    #3 rst_n = 1;
    #1 check_all("areset.rel");
    tick();
    check_all("areset.first");

    // randomized run
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 0;
        #1 m = bubble();
        check_all("rnd.rst");
        tick();
        rst_n = 1;
      end else begin
        #1 check_all("rnd");
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
